// File: rtl/sprite_pixel_fetch.sv
// Single-sprite pixel fetch: box test, glyph ROM addressing and transparency keying, 3-cycle fixed latency.
// Optional horizontal mirroring is built when SPRITE_FLIP_EN is defined.
module sprite_pixel_fetch #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 12,
    parameter int GLYPH_BITS = 4,
    parameter logic [DATA_WIDTH-1:0] TRANSPARENT_KEY = 24'hFF00FF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            hcount,
    input  logic [9:0]            vcount,
    input  logic                  pix_valid,
    input  logic                  frame_start,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [9:0]            upd_x,
    input  logic [9:0]            upd_y,
    input  logic [GLYPH_BITS-1:0] upd_glyph,
`ifdef SPRITE_FLIP_EN
    input  logic                  upd_hflip,
`endif
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic                  px_valid,
    output logic                  px_hit,
    output logic [DATA_WIDTH-1:0] px_rgb
);

    // Handshake: an update transfers on a rising edge where upd_valid && upd_ready.
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t state, state_next;
    logic   accept, commit;

    logic [9:0]            stg_x, stg_y, act_x, act_y;
    logic [GLYPH_BITS-1:0] stg_glyph, act_glyph;
    logic                  sprite_en;
`ifdef SPRITE_FLIP_EN
    logic                  stg_hflip, act_hflip;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        upd_ready  = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                upd_ready = 1'b1;
                if (upd_valid) begin
                    accept     = 1'b1;
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (frame_start) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_x     <= '0;
            stg_y     <= '0;
            stg_glyph <= '0;
        end else if (accept) begin
            stg_x     <= upd_x;
            stg_y     <= upd_y;
            stg_glyph <= upd_glyph;
        end
    end

    // Active copy only changes at frame start, so the visible sprite never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_x     <= '0;
            act_y     <= '0;
            act_glyph <= '0;
            sprite_en <= 1'b0;
        end else if (commit) begin
            act_x     <= stg_x;
            act_y     <= stg_y;
            act_glyph <= stg_glyph;
            sprite_en <= 1'b1;
        end
    end

`ifdef SPRITE_FLIP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_hflip <= 1'b0;
            act_hflip <= 1'b0;
        end else begin
            if (accept) stg_hflip <= upd_hflip;
            if (commit) act_hflip <= stg_hflip;
        end
    end
`endif

    // 11-bit differences keep a sprite near column 1023 from wrapping onto column 0.
    logic [10:0]               dx, dy;
    logic                      in_box;
    logic [3:0]                col;
    logic [GLYPH_BITS+7:0]     addr_raw;

    always_comb begin
        dx     = {1'b0, hcount} - {1'b0, act_x};
        dy     = {1'b0, vcount} - {1'b0, act_y};
        in_box = sprite_en & pix_valid
               & (hcount >= act_x) & (dx < 11'd16)
               & (vcount >= act_y) & (dy < 11'd16);
`ifdef SPRITE_FLIP_EN
        col    = act_hflip ? (4'd15 - dx[3:0]) : dx[3:0];
`else
        col    = dx[3:0];
`endif
        addr_raw = {act_glyph, dy[3:0], col};
    end

    logic v1, h1, v2, h2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            v1       <= 1'b0;
            h1       <= 1'b0;
            v2       <= 1'b0;
            h2       <= 1'b0;
        end else begin
            rom_addr <= in_box ? ADDR_WIDTH'(addr_raw) : '0;
            v1       <= pix_valid;
            h1       <= in_box;
            v2       <= v1;
            h2       <= h1;
        end
    end

    logic opaque;
    assign opaque = h2 & (rom_q != TRANSPARENT_KEY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_valid <= 1'b0;
            px_hit   <= 1'b0;
            px_rgb   <= '0;
        end else begin
            px_valid <= v2;
            px_hit   <= opaque;
            px_rgb   <= opaque ? rom_q : '0;
        end
    end

endmodule
